// File: rtl/type2_array_pkg.sv
// Shared types and helpers for the parametrised type2 dot-product array.
package type2_array_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SWAP  = 2'd2
    } state_e;

    // Cycles from input acceptance to result: input reg, product reg, one add reg per lane.
    function automatic int lat(input int nb);
        return nb + 32'sd2;
    endfunction

    function automatic int idx_w(input int nb);
        return (nb > 32'sd1) ? $clog2(nb) : 32'sd1;
    endfunction

endpackage

// File: rtl/type2_cell.sv
// One lane of the transposed chain: input skew, registered multiply, registered add.
module type2_cell #(
    parameter int IMG_WIDTH = 16,
    parameter int KER_WIDTH = 8,
    parameter int SUM_WIDTH = 27,
    parameter int DEPTH     = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [IMG_WIDTH-1:0] x,
    input  logic signed [KER_WIDTH-1:0] w,
    input  logic signed [SUM_WIDTH-1:0] sum_in,
    output logic signed [SUM_WIDTH-1:0] sum_out
);

    localparam int PROD_W = IMG_WIDTH + KER_WIDTH;

    logic signed [IMG_WIDTH-1:0] skew_r [0:DEPTH];
    logic signed [PROD_W-1:0]    prod_r;
    logic signed [SUM_WIDTH-1:0] sum_r;

    // Skew line, product and partial-sum registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= DEPTH; i++) begin
                skew_r[i] <= '0;
            end
            prod_r <= '0;
            sum_r  <= '0;
        end else begin
            skew_r[0] <= x;
            for (int i = 1; i <= DEPTH; i++) begin
                skew_r[i] <= skew_r[i-1];
            end
            prod_r <= PROD_W'(skew_r[DEPTH]) * PROD_W'(w);
            sum_r  <= SUM_WIDTH'(prod_r) + sum_in;
        end
    end

    assign sum_out = sum_r;

endmodule

// File: rtl/type2_array.sv
// Parametrised signed dot-product array with double-buffered weights and a
// drain-then-swap controller so every sample sees one consistent weight set.
module type2_array
    import type2_array_pkg::*;
#(
    parameter int IMG_WIDTH = 16,
    parameter int KER_WIDTH = 8,
    parameter int IMG_NB    = 3,
    parameter int OUT_WIDTH = IMG_WIDTH + KER_WIDTH + $clog2(IMG_NB) + 32'sd1,
    parameter bit SATURATE  = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [IMG_WIDTH*IMG_NB-1:0]   img,
    input  logic                          val,
    output logic                          rdy,
    input  logic signed [KER_WIDTH-1:0]   ker,
    input  logic [idx_w(IMG_NB)-1:0]      ker_idx,
    input  logic                          ker_wr,
    input  logic                          ker_swap,
    output logic                          ker_busy,
    output logic signed [OUT_WIDTH-1:0]   result,
    output logic                          result_val
);

    localparam int LAT   = lat(IMG_NB);
    localparam int IDX_W = idx_w(IMG_NB);
    localparam int SUM_W = IMG_WIDTH + KER_WIDTH + $clog2(IMG_NB) + 32'sd1;

    state_e                      state_r;
    state_e                      state_next_s;
    logic                        rdy_r;
    logic                        busy_r;
    logic                        rdy_next_s;
    logic                        busy_next_s;
    logic                        load_s;
    logic                        accept_s;
    logic [LAT-1:0]              tok_r;
    logic signed [KER_WIDTH-1:0] act_r [IMG_NB];
    logic signed [KER_WIDTH-1:0] shd_r [IMG_NB];
    logic signed [IMG_WIDTH-1:0] lane_s [IMG_NB];
    logic signed [SUM_W-1:0]     chain_in_s [IMG_NB];
    logic signed [SUM_W-1:0]     part_s [IMG_NB];
    logic signed [SUM_W-1:0]     full_s;
    logic signed [OUT_WIDTH-1:0] out_s;
    logic signed [OUT_WIDTH-1:0] result_r;
    logic                        result_val_r;

    assign accept_s = val && rdy_r;

    // Controller next state
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RUN: begin
                if (ker_swap) state_next_s = DRAIN;
                else          state_next_s = RUN;
            end
            DRAIN: begin
                if (tok_r == '0) state_next_s = SWAP;
                else             state_next_s = DRAIN;
            end
            SWAP:    state_next_s = RUN;
            default: state_next_s = RUN;
        endcase
    end

    // Controller output decode (handshake flags are registered from the next state)
    always_comb begin
        rdy_next_s  = (state_next_s == RUN);
        busy_next_s = (state_next_s != RUN);
        load_s      = (state_r == SWAP);
    end

    // Controller state, handshake flags and valid-token line
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
            rdy_r   <= 1'b1;
            busy_r  <= 1'b0;
            tok_r   <= '0;
        end else begin
            state_r <= state_next_s;
            rdy_r   <= rdy_next_s;
            busy_r  <= busy_next_s;
            tok_r   <= {tok_r[LAT-2:0], accept_s};
        end
    end

    // Weight banks: the copy reads the shadow before a same-cycle write lands
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IMG_NB; i++) begin
                act_r[i] <= '0;
                shd_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < IMG_NB; i++) begin
                if (load_s) act_r[i] <= shd_r[i];
                if (ker_wr && (ker_idx == IDX_W'(i))) shd_r[i] <= ker;
            end
        end
    end

    for (genvar k = 0; k < IMG_NB; k++) begin : g_lane
        assign lane_s[k] = accept_s ? $signed(img[k*IMG_WIDTH +: IMG_WIDTH]) : '0;

        if (k == 0) begin : g_head
            assign chain_in_s[k] = '0;
        end else begin : g_link
            assign chain_in_s[k] = part_s[k-1];
        end

        type2_cell #(
            .IMG_WIDTH (IMG_WIDTH),
            .KER_WIDTH (KER_WIDTH),
            .SUM_WIDTH (SUM_W),
            .DEPTH     (k)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .x       (lane_s[k]),
            .w       (act_r[k]),
            .sum_in  (chain_in_s[k]),
            .sum_out (part_s[k])
        );
    end

    assign full_s = part_s[IMG_NB-1];

    if (SATURATE && (OUT_WIDTH < SUM_W)) begin : g_sat
        localparam logic signed [SUM_W-1:0] SAT_MAX =
            {{(SUM_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
        localparam logic signed [SUM_W-1:0] SAT_MIN =
            {{(SUM_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

        // Clamp the full-precision sum into the signed output range
        always_comb begin
            if (full_s > SAT_MAX)      out_s = SAT_MAX[OUT_WIDTH-1:0];
            else if (full_s < SAT_MIN) out_s = SAT_MIN[OUT_WIDTH-1:0];
            else                       out_s = full_s[OUT_WIDTH-1:0];
        end
    end else begin : g_wrap
        // Sign-extends when wider, keeps the low bits when narrower
        assign out_s = OUT_WIDTH'(full_s);
    end

    // Result register holds its value across bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r     <= '0;
            result_val_r <= 1'b0;
        end else begin
            result_val_r <= tok_r[LAT-1];
            if (tok_r[LAT-1]) result_r <= out_s;
        end
    end

    assign rdy        = rdy_r;
    assign ker_busy   = busy_r;
    assign result     = result_r;
    assign result_val = result_val_r;

endmodule
